fp_to_int_converter: RTL

Downstream consumer of the floating-point adder result word. Accepts one 32-bit custom float (sign, 6-bit exponent, 25-bit fraction, hidden leading 1) per handshake. Converts it to a two's-complement signed integer, truncating toward zero, with saturation. Uses an iterative one-bit-per-cycle shifter and valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 42 ++++
 rtl/fp_shift_unit.sv | 64 ++++++
 rtl/fp_to_int_converter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared float-format definitions for the adder and float-to-integer stages.
package fp_pkg;

  localparam int unsigned EXP_W     = 6;
  localparam int unsigned MAN_W     = 25;
  localparam int unsigned SIG_W     = MAN_W + 1;
  localparam int unsigned WORD_W    = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS      = 31;
  localparam int unsigned SHIFT_REF = BIAS + MAN_W;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned STATUS_W  = 4;
  localparam int unsigned FLAG_W    = 4;

  localparam int unsigned FLAG_EXACT    = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_UNDERFLW = 2;
  localparam int unsigned FLAG_INEXACT  = 3;

  localparam logic [FLAG_W-1:0] FL_EXACT    = FLAG_W'(1 << FLAG_EXACT);
  localparam logic [FLAG_W-1:0] FL_OVERFLOW = FLAG_W'(1 << FLAG_OVERFLOW);
  localparam logic [FLAG_W-1:0] FL_UNDERFLW = FLAG_W'(1 << FLAG_UNDERFLW);
  localparam logic [FLAG_W-1:0] FL_INEXACT  = FLAG_W'(1 << FLAG_INEXACT);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp_word_t;

  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, NEGATE, DONE} conv_state_e;

  // Sign is the word MSB, followed by exponent, then fraction.
  function automatic fp_word_t fp_unpack(input logic [WORD_W-1:0] w);
    return fp_word_t'(w);
  endfunction

  // Significand with the hidden leading one restored.
  function automatic logic [SIG_W-1:0] fp_mant(input logic [MAN_W-1:0] frac);
    return {1'b1, frac};
  endfunction

endpackage

// File: rtl/fp_shift_unit.sv
// Iterative one-bit-per-cycle shifter; right shifts collect dropped bits into sticky.
module fp_shift_unit
  import fp_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     load_acc,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             load_left,
  output logic [W-1:0]     acc,
  output logic             sticky,
  output logic             done_c
);

  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sticky_d = sticky_q;
    if (load) begin
      acc_d    = load_acc;
      cnt_d    = load_cnt;
      left_d   = load_left;
      sticky_d = 1'b0;
    end else if (step) begin
      if (left_q) begin
        acc_d = acc_q << 1;
      end else begin
        acc_d    = acc_q >> 1;
        sticky_d = sticky_q | acc_q[0];
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sticky_q <= sticky_d;
    end
  end

  assign acc    = acc_q;
  assign sticky = sticky_q;
  // The step taken while cnt==1 is the last one.
  assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fp_to_int_converter.sv
// Converts one custom float per handshake to a saturating, truncated signed integer.
module fp_to_int_converter
  import fp_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic                clock_100kHz,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic [STATUS_W-1:0] in_status,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [FLAG_W-1:0]   out_flags,
  output logic [STATUS_W-1:0] out_status
);

  localparam logic [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_MAX - EXP_W'(1);

  conv_state_e         state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MAN_W-1:0]    frac_q, frac_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [FLAG_W-1:0]   out_flags_q, out_flags_d;
  logic [STATUS_W-1:0] out_status_q, out_status_d;

  logic             sh_load, sh_step, sh_left, sh_sticky, sh_done_c;
  logic [CNT_W-1:0] sh_cnt;
  logic [OUT_W-1:0] sh_acc;
  fp_word_t         in_word;

  assign in_word = fp_unpack(in_data);

  fp_shift_unit #(.W(OUT_W)) u_shift (
    .clk       (clock_100kHz),
    .reset     (reset),
    .load      (sh_load),
    .step      (sh_step),
    .load_acc  (OUT_W'(fp_mant(frac_q))),
    .load_cnt  (sh_cnt),
    .load_left (sh_left),
    .acc       (sh_acc),
    .sticky    (sh_sticky),
    .done_c    (sh_done_c)
  );

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    frac_d       = frac_q;
    status_d     = status_q;
    out_data_d   = out_data_q;
    out_flags_d  = out_flags_q;
    out_status_d = out_status_q;
    sh_load      = 1'b0;
    sh_step      = 1'b0;
    // Integer value is mant * 2^(exp - SHIFT_REF); direction and distance follow.
    sh_left      = (exp_q >= EXP_W'(SHIFT_REF));
    sh_cnt       = sh_left ? CNT_W'(exp_q - EXP_W'(SHIFT_REF))
                           : CNT_W'(EXP_W'(SHIFT_REF) - exp_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d   = in_word.sign;
          exp_d    = in_word.exp;
          frac_d   = in_word.frac;
          status_d = in_status;
          state_d  = CLASSIFY;
        end
      end
      CLASSIFY: begin
        if (exp_q == '0) begin
          out_data_d  = '0;
          out_flags_d = FL_EXACT;
          state_d     = DONE;
        end else if (exp_q == EXP_MAX ||
                     (exp_q == EXP_TOP && (frac_q != '0 || !sign_q))) begin
          out_data_d  = sign_q ? INT_MIN : INT_MAX;
          out_flags_d = FL_OVERFLOW;
          state_d     = DONE;
        end else if (exp_q == EXP_TOP) begin
          // Exactly -2^31 is representable.
          out_data_d  = INT_MIN;
          out_flags_d = FL_EXACT;
          state_d     = DONE;
        end else if (exp_q < EXP_W'(BIAS)) begin
          out_data_d  = '0;
          out_flags_d = FL_UNDERFLW | FL_INEXACT;
          state_d     = DONE;
        end else begin
          sh_load = 1'b1;
          state_d = (sh_cnt == '0) ? NEGATE : SHIFT;
        end
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_done_c) begin
          state_d = NEGATE;
        end
      end
      NEGATE: begin
        out_data_d  = sign_q ? (~sh_acc + OUT_W'(1)) : sh_acc;
        out_flags_d = sh_sticky ? FL_INEXACT : FL_EXACT;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) begin
      out_status_d = status_q;
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      frac_q       <= '0;
      status_q     <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_flags_q  <= '0;
      out_status_q <= '0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      frac_q       <= frac_d;
      status_q     <= status_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
      out_status_q <= out_status_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_flags  = out_flags_q;
  assign out_status = out_status_q;

endmodule
